// File: rtl/alu_pkg.sv
// alu_pkg: opcode/function constants, MDU state encoding and flag bit indices
package alu_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_CALL  = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SUBI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_BEQZ  = 6'h10;
    localparam logic [5:0] OP_BNEZ  = 6'h11;
    localparam logic [5:0] OP_BRFL  = 6'h12;
    localparam logic [5:0] OP_JALR  = 6'h13;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_NOT   = 6'h27;
    localparam logic [5:0] FN_CMP   = 6'h2A;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} mdu_state_t;
    localparam int F_OVF   = 3;
    localparam int F_ABOVE = 2;
    localparam int F_EQUAL = 1;
    localparam int F_ERROR = 0;
endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative unsigned shift-add multiplier / restoring divider, one bit per cycle
module mdu_iter import alu_pkg::*; #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  is_div,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] lo,
    output logic [DATA_WIDTH-1:0] hi,
    output logic                  ovf,
    output logic                  dz
);
    localparam int CW = $clog2(DATA_WIDTH);
    mdu_state_t state;
    logic [CW-1:0] cnt;
    logic [DATA_WIDTH-1:0] opd, whi, wlo, nhi, nlo;
    logic [DATA_WIDTH:0] sum, rsh;
    logic div_r, ge;
    // Working registers are separate so HI/LO only change on completion
    always_comb begin
        sum = {1'b0, whi} + (wlo[0] ? {1'b0, opd} : '0);
        rsh = {whi, wlo[DATA_WIDTH-1]};
        ge  = rsh >= {1'b0, opd};
        nhi = (state == S_DIV) ? (ge ? rsh[DATA_WIDTH-1:0] - opd : rsh[DATA_WIDTH-1:0]) : sum[DATA_WIDTH:1];
        nlo = (state == S_DIV) ? {wlo[DATA_WIDTH-2:0], ge} : {sum[0], wlo[DATA_WIDTH-1:1]};
    end
    assign ovf = !div_r && (hi != '0);
    assign dz  = div_r && (opd == '0);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            opd   <= '0;
            whi   <= '0;
            wlo   <= '0;
            hi    <= '0;
            lo    <= '0;
            div_r <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    div_r <= is_div;
                    opd   <= is_div ? b : a;
                    wlo   <= is_div ? a : b;
                    whi   <= '0;
                    cnt   <= CW'(DATA_WIDTH - 1);
                    if (is_div && b == '0) begin
                        lo    <= '1;
                        hi    <= a;
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= is_div ? S_DIV : S_MUL;
                        busy  <= 1'b1;
                    end
                end
                S_MUL, S_DIV: begin
                    whi <= nhi;
                    wlo <= nlo;
                    if (cnt == '0) begin
                        hi    <= nhi;
                        lo    <= nlo;
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else
                        cnt <= cnt - 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage ALU with flag register, branch evaluation and iterative MDU
module alu_mdu import alu_pkg::*; #(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_WIDTH   = 6,
    parameter int FUNCTION_WIDTH = 6,
    parameter int PC_WIDTH       = 32,
    parameter int FLAGS_WIDTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [DATA_WIDTH-1:0]     alu_data_a_in,
    input  logic [DATA_WIDTH-1:0]     alu_data_b_in,
    input  logic [OPCODE_WIDTH-1:0]   alu_opcode_in,
    input  logic [FUNCTION_WIDTH-1:0] alu_function_in,
    input  logic [PC_WIDTH-1:0]       pc_in,
    output logic                      alu_branch_result_out,
    output logic [DATA_WIDTH-1:0]     alu_data_out,
    output logic [DATA_WIDTH-1:0]     hi_data_out,
    output logic                      alu_busy_out,
    output logic                      alu_done_out,
    output logic [FLAGS_WIDTH-1:0]    flags_out
);
    localparam int M = DATA_WIDTH - 1;
    logic [DATA_WIDTH-1:0] a, b, sum, dif, res, lo, link;
    logic [FLAGS_WIDTH-1:0] fl, mdu_fl;
    logic rtype, is_mul, is_div, idle, start, mdu_ovf, mdu_dz;
    assign a      = alu_data_a_in;
    assign b      = alu_data_b_in;
    assign sum    = a + b;
    assign dif    = a - b;
    assign link   = DATA_WIDTH'(pc_in);
    assign rtype  = alu_opcode_in == OP_RTYPE;
    assign is_mul = rtype && alu_function_in == FN_MULT;
    assign is_div = rtype && alu_function_in == FN_DIV;
    assign idle   = !alu_busy_out && !alu_done_out;
    assign start  = en && idle && (is_mul || is_div);
    always_comb begin
        res = '0;
        fl  = '0;
        if (rtype)
            case (alu_function_in)
                FN_ADD: begin
                    res = sum;
                    fl[F_OVF] = (a[M] == b[M]) && (sum[M] != a[M]);
                end
                FN_SUB: begin
                    res = dif;
                    fl[F_OVF] = (a[M] != b[M]) && (dif[M] != a[M]);
                end
                FN_CMP: begin
                    res = dif;
                    fl[F_EQUAL] = a == b;
                    fl[F_ABOVE] = $signed(a) > $signed(b);
                end
                FN_AND:  res = a & b;
                FN_OR:   res = a | b;
                FN_NOT:  res = ~b;
                FN_MULT, FN_DIV: res = '0;
                default: fl[F_ERROR] = 1'b1;
            endcase
        else
            case (alu_opcode_in)
                OP_ADDI, OP_LW, OP_SW:     res = sum;
                OP_SUBI:                   res = dif;
                OP_ANDI:                   res = a & b;
                OP_ORI:                    res = a | b;
                OP_JAL, OP_CALL, OP_JALR:  res = link;
                default:                   res = '0;
            endcase
    end
    always_comb begin
        mdu_fl = '0;
        mdu_fl[F_OVF]   = mdu_ovf;
        mdu_fl[F_ERROR] = mdu_dz;
    end
    always_ff @(posedge clk) begin
        if (!rst_n)
            flags_out <= '0;
        else if (alu_done_out)
            flags_out <= mdu_fl;
        else if (en && idle && !is_mul && !is_div)
            flags_out <= fl;
    end
    assign alu_branch_result_out = (alu_opcode_in == OP_BEQZ) ? (a == '0) :
                                   (alu_opcode_in == OP_BNEZ) ? (a != '0) :
                                   (alu_opcode_in == OP_BRFL) ? (flags_out == b[FLAGS_WIDTH-1:0]) : 1'b0;
    assign alu_data_out = alu_done_out ? lo : res;
    mdu_iter #(.DATA_WIDTH(DATA_WIDTH)) u_mdu (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .is_div (is_div),
        .a      (a),
        .b      (b),
        .busy   (alu_busy_out),
        .done   (alu_done_out),
        .lo     (lo),
        .hi     (hi_data_out),
        .ovf    (mdu_ovf),
        .dz     (mdu_dz)
    );
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: table-driven checks of combinational ops, flags and branches, plus MDU sequences
module tb_alu_mdu;
    import alu_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic [31:0] a = '0, b = '0, pc = '0, out, hi;
    logic [5:0] op = 6'h3F, fn = '0;
    logic br, busy, done;
    logic [3:0] flags;
    int total = 0, passed = 0;
    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [31:0] res;
        logic        br;
        logic [3:0]  fl;
    } vec_t;
    vec_t vt [26];
    alu_mdu dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .en                    (en),
        .alu_data_a_in         (a),
        .alu_data_b_in         (b),
        .alu_opcode_in         (op),
        .alu_function_in       (fn),
        .pc_in                 (pc),
        .alu_branch_result_out (br),
        .alu_data_out          (out),
        .hi_data_out           (hi),
        .alu_busy_out          (busy),
        .alu_done_out          (done),
        .flags_out             (flags)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    task automatic start_op(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        en = 1'b1; op = OP_RTYPE; fn = f; a = av; b = bv;
        @(posedge clk); #1;
        en = 1'b0; op = 6'h3F;
    endtask
    initial begin
        int nb, nd;
        vt[0]  = '{OP_RTYPE, FN_ADD,  32'h7FFFFFFF, 32'h1,        32'h0,        32'h80000000, 1'b0, 4'b1000};
        vt[1]  = '{OP_RTYPE, FN_SUB,  32'h80000000, 32'h1,        32'h0,        32'h7FFFFFFF, 1'b0, 4'b1000};
        vt[2]  = '{OP_ADDI,  6'h00,   32'h7FFFFFFF, 32'h1,        32'h0,        32'h80000000, 1'b0, 4'b0000};
        vt[3]  = '{OP_RTYPE, FN_AND,  32'hF0F01234, 32'h0FF0FFFF, 32'h0,        32'h00F01234, 1'b0, 4'b0000};
        vt[4]  = '{OP_RTYPE, FN_OR,   32'hA,        32'h5,        32'h0,        32'hF,        1'b0, 4'b0000};
        vt[5]  = '{OP_ORI,   6'h00,   32'h12000000, 32'h34,       32'h0,        32'h12000034, 1'b0, 4'b0000};
        vt[6]  = '{OP_ANDI,  6'h00,   32'hFFFF00FF, 32'h0F0F0F0F, 32'h0,        32'h0F0F000F, 1'b0, 4'b0000};
        vt[7]  = '{OP_RTYPE, FN_NOT,  32'h12345678, 32'h0000FFFF, 32'h0,        32'hFFFF0000, 1'b0, 4'b0000};
        vt[8]  = '{OP_JAL,   6'h00,   32'h5,        32'h6,        32'h100,      32'h100,      1'b0, 4'b0000};
        vt[9]  = '{OP_CALL,  6'h00,   32'h5,        32'h6,        32'hDEADBEEC, 32'hDEADBEEC, 1'b0, 4'b0000};
        vt[10] = '{OP_JALR,  6'h00,   32'h5,        32'h6,        32'h40,       32'h40,       1'b0, 4'b0000};
        vt[11] = '{OP_RTYPE, 6'h3F,   32'h1,        32'h2,        32'h0,        32'h0,        1'b0, 4'b0001};
        vt[12] = '{OP_LW,    6'h00,   32'h1000,     32'hFFFFFFFC, 32'h0,        32'hFFC,      1'b0, 4'b0000};
        vt[13] = '{OP_SUBI,  6'h00,   32'd10,       32'd3,        32'h0,        32'd7,        1'b0, 4'b0000};
        vt[14] = '{OP_SW,    6'h00,   32'h8,        32'h4,        32'h0,        32'hC,        1'b0, 4'b0000};
        vt[15] = '{OP_RTYPE, FN_CMP,  32'hFFFFFFFF, 32'h1,        32'h0,        32'hFFFFFFFE, 1'b0, 4'b0000};
        vt[16] = '{OP_RTYPE, FN_CMP,  32'h5,        32'h5,        32'h0,        32'h0,        1'b0, 4'b0010};
        vt[17] = '{OP_BRFL,  6'h00,   32'h0,        32'h2,        32'h0,        32'h0,        1'b1, 4'b0000};
        vt[18] = '{OP_RTYPE, FN_CMP,  32'h7,        32'h3,        32'h0,        32'h4,        1'b0, 4'b0100};
        vt[19] = '{OP_BRFL,  6'h00,   32'h0,        32'h4,        32'h0,        32'h0,        1'b1, 4'b0000};
        vt[20] = '{OP_BRFL,  6'h00,   32'h0,        32'h4,        32'h0,        32'h0,        1'b0, 4'b0000};
        vt[21] = '{OP_BEQZ,  6'h00,   32'h0,        32'h9,        32'h0,        32'h0,        1'b1, 4'b0000};
        vt[22] = '{OP_BNEZ,  6'h00,   32'h0,        32'h9,        32'h0,        32'h0,        1'b0, 4'b0000};
        vt[23] = '{OP_BNEZ,  6'h00,   32'h5,        32'h9,        32'h0,        32'h0,        1'b1, 4'b0000};
        vt[24] = '{OP_RTYPE, FN_SUB,  32'h0,        32'h80000000, 32'h0,        32'h80000000, 1'b0, 4'b1000};
        vt[25] = '{6'h3F,    6'h00,   32'h1,        32'h1,        32'h0,        32'h0,        1'b0, 4'b0000};
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_flags", 32'(flags), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_hi", hi, 32'h0);
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            en = 1'b1; op = vt[i].op; fn = vt[i].fn; a = vt[i].a; b = vt[i].b; pc = vt[i].pc;
            #1;
            chk($sformatf("vec%0d_res", i), out, vt[i].res);
            chk($sformatf("vec%0d_br", i), 32'(br), 32'(vt[i].br));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_flags", i), 32'(flags), 32'(vt[i].fl));
        end
        en = 1'b0;
        // MULT 0x30000 * 0x50000 = 0xF_0000_0000
        start_op(FN_MULT, 32'h00030000, 32'h00050000);
        nb = 0;
        for (int i = 0; i < 32; i++) begin
            if (busy && !done) nb++;
            @(posedge clk); #1;
        end
        chk("mult_busy_cycles", 32'(nb), 32'd32);
        chk("mult_done", 32'(done), 32'h1);
        chk("mult_busy_end", 32'(busy), 32'h0);
        chk("mult_lo", out, 32'h0);
        chk("mult_hi", hi, 32'hF);
        @(posedge clk); #1;
        chk("mult_done_pulse", 32'(done), 32'h0);
        chk("mult_flags", 32'(flags), 32'h8);
        // DIV 100/7 with ignored instructions while busy
        start_op(FN_DIV, 32'd100, 32'd7);
        nb = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < 20) begin
                en = 1'b1; op = OP_RTYPE; fn = (i % 2 == 0) ? FN_ADD : FN_DIV;
                a = 32'h7FFFFFFF; b = (i % 2 == 0) ? 32'h7FFFFFFF : 32'h0;
            end else begin
                en = 1'b0; op = 6'h3F;
            end
            if (i == 25) chk("div_flags_hold", 32'(flags), 32'h8);
            if (i == 10) chk("div_hi_hold", hi, 32'hF);
            if (busy && !done) nb++;
            @(posedge clk); #1;
        end
        chk("div_busy_cycles", 32'(nb), 32'd32);
        chk("div_done", 32'(done), 32'h1);
        chk("div_lo", out, 32'd14);
        chk("div_hi", hi, 32'd2);
        @(posedge clk); #1;
        chk("div_done_pulse", 32'(done), 32'h0);
        chk("div_flags", 32'(flags), 32'h0);
        // Divide by zero completes immediately
        start_op(FN_DIV, 32'h1234, 32'h0);
        chk("dz_done", 32'(done), 32'h1);
        chk("dz_busy", 32'(busy), 32'h0);
        chk("dz_lo", out, 32'hFFFFFFFF);
        chk("dz_hi", hi, 32'h1234);
        @(posedge clk); #1;
        chk("dz_done_pulse", 32'(done), 32'h0);
        chk("dz_busy_after", 32'(busy), 32'h0);
        chk("dz_flags", 32'(flags), 32'h1);
        // Reset in the middle of a MULT
        start_op(FN_MULT, 32'h3, 32'h5);
        repeat (9) @(posedge clk);
        #1;
        chk("rst_mid_busy_before", 32'(busy), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_done", 32'(done), 32'h0);
        chk("rst_mid_hi", hi, 32'h0);
        chk("rst_mid_flags", 32'(flags), 32'h0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) nd++;
        end
        chk("rst_mid_no_done", 32'(nd), 32'h0);
        chk("rst_mid_hi_after", hi, 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
